// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared state encoding, grant codes and byte-lane constant
//    for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACCESS  = 2'd1,
      ST_RESPOND = 2'd2
   } state_t;
   localparam logic [1:0] GNT_NONE = 2'b00;
   localparam logic [1:0] GNT_I    = 2'b01;
   localparam logic [1:0] GNT_D    = 2'b10;
   localparam logic [3:0] BE_WORD  = 4'b1111;
endpackage

// File: rtl/mem_port_arbiter_arb_rr2.sv
// arb_rr2: combinational two-way round-robin pick between fetch and data.
//    req_i_i  - instruction request
//    req_d_i  - data request
//    last_d_i - 1 when data was served last
//    grant_o  - GNT_NONE / GNT_I / GNT_D
module arb_rr2
   import mem_port_arbiter_pkg::*;
(
   input  logic       req_i_i,
   input  logic       req_d_i,
   input  logic       last_d_i,
   output logic [1:0] grant_o
);
   always_comb
      grant_o = (req_i_i && req_d_i) ? (last_d_i ? GNT_I : GNT_D) :
                req_i_i              ? GNT_I :
                req_d_i              ? GNT_D : GNT_NONE;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the fetch and data buses,
//    one access at a time, holding the port MEM_LATENCY cycles per access.
//    iCLK/iRST                     - clock, async active-high reset
//    iIReq/iIAddress               - fetch request and address
//    oIReady/oIReadData            - fetch done pulse and word
//    iDReq/iDWrite/iDByteEnable/iDAddress/iDWriteData - data request
//    oDReady/oDReadData            - data done pulse and load word (0 for stores)
//    oM*/iMReadData                - shared memory port
//    oGrant/oBusy                  - monitor outputs
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int MEM_LATENCY = 1
) (
   input  logic        iCLK,
   input  logic        iRST,
   input  logic        iIReq,
   input  logic [31:0] iIAddress,
   output logic        oIReady,
   output logic [31:0] oIReadData,
   input  logic        iDReq,
   input  logic        iDWrite,
   input  logic [3:0]  iDByteEnable,
   input  logic [31:0] iDAddress,
   input  logic [31:0] iDWriteData,
   output logic        oDReady,
   output logic [31:0] oDReadData,
   output logic        oMReadEnable,
   output logic        oMWriteEnable,
   output logic [3:0]  oMByteEnable,
   output logic [31:0] oMAddress,
   output logic [31:0] oMWriteData,
   input  logic [31:0] iMReadData,
   output logic [1:0]  oGrant,
   output logic        oBusy
);
   localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

   state_t      state_q;
   logic [1:0]  grant_q;
   logic [1:0]  grant_d;
   logic        last_d_q;
   logic        write_q;
   logic        store_d;
   logic [3:0]  cnt_q;
   logic [3:0]  be_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;
   logic        acc;
   logic        rsp;

   arb_rr2 u_arb (
      .req_i_i (iIReq),
      .req_d_i (iDReq),
      .last_d_i(last_d_q),
      .grant_o (grant_d)
   );

   assign store_d = (grant_d == GNT_D) && iDWrite;

   always_ff @(posedge iCLK or posedge iRST)
      if (iRST) begin
         state_q  <= ST_IDLE;
         grant_q  <= GNT_NONE;
         last_d_q <= 1'b0;
         write_q  <= 1'b0;
         cnt_q    <= '0;
         be_q     <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
      end else
         case (state_q)
            ST_IDLE:
               if (grant_d != GNT_NONE) begin
                  grant_q <= grant_d;
                  write_q <= store_d;
                  addr_q  <= (grant_d == GNT_D) ? iDAddress : iIAddress;
                  be_q    <= store_d ? iDByteEnable : BE_WORD;
                  wdata_q <= store_d ? iDWriteData : '0;
                  cnt_q   <= CNT_INIT;
                  state_q <= ST_ACCESS;
               end
            ST_ACCESS:
               if (cnt_q == '0) begin
                  rdata_q <= write_q ? '0 : iMReadData;
                  state_q <= ST_RESPOND;
               end else
                  cnt_q <= cnt_q - 4'd1;
            ST_RESPOND: begin
               last_d_q <= (grant_q == GNT_D);
               state_q  <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase

   // All outputs decode from registers only, so reset clears them immediately.
   assign acc           = (state_q == ST_ACCESS);
   assign rsp           = (state_q == ST_RESPOND);
   assign oMReadEnable  = acc && !write_q;
   // Single write strobe on the final access cycle.
   assign oMWriteEnable = acc && write_q && (cnt_q == '0);
   assign oMByteEnable  = acc ? be_q : '0;
   assign oMAddress     = acc ? addr_q : '0;
   assign oMWriteData   = acc ? wdata_q : '0;
   assign oIReady       = rsp && (grant_q == GNT_I);
   assign oDReady       = rsp && (grant_q == GNT_D);
   assign oIReadData    = oIReady ? rdata_q : '0;
   assign oDReadData    = oDReady ? rdata_q : '0;
   assign oGrant        = (acc || rsp) ? grant_q : GNT_NONE;
   assign oBusy         = (state_q != ST_IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of the arbiter at MEM_LATENCY 1 and 3.
module tb_mem_port_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic ireq, dreq, dwr;
   logic [31:0] iaddr, daddr, dwd, mrd;
   logic [3:0] dbe;

   logic ir1, dr1, mre1, mwe1, busy1;
   logic [31:0] ird1, drd1, ma1, mwd1;
   logic [3:0] mbe1;
   logic [1:0] gnt1;
   logic ir3, dr3, mre3, mwe3, busy3;
   logic [31:0] ird3, drd3, ma3, mwd3;
   logic [3:0] mbe3;
   logic [1:0] gnt3;

   bit sel3 = 1'b0;
   wire s_ir = sel3 ? ir3 : ir1;
   wire s_dr = sel3 ? dr3 : dr1;
   wire s_mre = sel3 ? mre3 : mre1;
   wire s_mwe = sel3 ? mwe3 : mwe1;
   wire s_busy = sel3 ? busy3 : busy1;
   wire [31:0] s_ird = sel3 ? ird3 : ird1;
   wire [31:0] s_drd = sel3 ? drd3 : drd1;
   wire [31:0] s_ma = sel3 ? ma3 : ma1;
   wire [31:0] s_mwd = sel3 ? mwd3 : mwd1;
   wire [3:0] s_mbe = sel3 ? mbe3 : mbe1;
   wire [1:0] s_gnt = sel3 ? gnt3 : gnt1;

   always #5 clk = ~clk;

   mem_port_arbiter #(.MEM_LATENCY(1)) u1 (
      .iCLK(clk), .iRST(rst),
      .iIReq(ireq), .iIAddress(iaddr), .oIReady(ir1), .oIReadData(ird1),
      .iDReq(dreq), .iDWrite(dwr), .iDByteEnable(dbe), .iDAddress(daddr), .iDWriteData(dwd),
      .oDReady(dr1), .oDReadData(drd1),
      .oMReadEnable(mre1), .oMWriteEnable(mwe1), .oMByteEnable(mbe1), .oMAddress(ma1),
      .oMWriteData(mwd1), .iMReadData(mrd), .oGrant(gnt1), .oBusy(busy1)
   );

   mem_port_arbiter #(.MEM_LATENCY(3)) u3 (
      .iCLK(clk), .iRST(rst),
      .iIReq(ireq), .iIAddress(iaddr), .oIReady(ir3), .oIReadData(ird3),
      .iDReq(dreq), .iDWrite(dwr), .iDByteEnable(dbe), .iDAddress(daddr), .iDWriteData(dwd),
      .oDReady(dr3), .oDReadData(drd3),
      .oMReadEnable(mre3), .oMWriteEnable(mwe3), .oMByteEnable(mbe3), .oMAddress(ma3),
      .oMWriteData(mwd3), .iMReadData(mrd), .oGrant(gnt3), .oBusy(busy3)
   );

   typedef struct {
      bit          on3;
      bit          isd;
      bit          wr;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] mdata;
      logic [31:0] exp_rd;
      logic [3:0]  exp_be;
      logic [1:0]  exp_gnt;
   } vec_t;

   localparam int NV = 5;
   vec_t tv [NV];
   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_all();
      rst = 1'b1;
      ireq = 1'b0; dreq = 1'b0; dwr = 1'b0;
      iaddr = '0; daddr = '0; dwd = '0; dbe = '0; mrd = '0;
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      vec_t t;
      int lat, np, dr_at, ir_at, npl;
      bit acc, rsp;
      tv[0] = '{0, 0, 0, 4'h0, 32'h0040_0000, 32'h0, 32'h0000_0013, 32'h0000_0013, 4'hF, 2'b01};
      tv[1] = '{0, 1, 0, 4'h3, 32'h1001_0004, 32'h1111_2222, 32'hCAFE_F00D, 32'hCAFE_F00D, 4'hF, 2'b10};
      tv[2] = '{1, 1, 1, 4'h3, 32'h1001_0000, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0, 4'h3, 2'b10};
      tv[3] = '{1, 0, 0, 4'h0, 32'h0040_0010, 32'h0, 32'h0010_0093, 32'h0010_0093, 4'hF, 2'b01};
      tv[4] = '{0, 1, 1, 4'h8, 32'h1001_0008, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 32'h0, 4'h8, 2'b10};

      ireq = 1'b0; dreq = 1'b0; dwr = 1'b0;
      iaddr = '0; daddr = '0; dwd = '0; dbe = '0; mrd = '0;
      #2 rst = 1'b1;
      #1;
      chk("reset_outputs_u1", 64'(|{ir1, ird1, dr1, drd1, mre1, mwe1, mbe1, ma1, mwd1, gnt1, busy1}), 0);
      chk("reset_outputs_u3", 64'(|{ir3, ird3, dr3, drd3, mre3, mwe3, mbe3, ma3, mwd3, gnt3, busy3}), 0);

      for (int v = 0; v < NV; v++) begin
         t = tv[v];
         lat = t.on3 ? 3 : 1;
         reset_all();
         sel3 = t.on3;
         ireq = !t.isd; dreq = t.isd; dwr = t.wr;
         iaddr = t.addr; daddr = t.addr; dwd = t.wdata; dbe = t.be; mrd = t.mdata;
         chk($sformatf("v%0d_c0_idle", v), 64'({s_busy, s_gnt, s_mre, s_mwe}), 0);
         for (int c = 1; c <= lat + 2; c++) begin
            step();
            if (c == 1) begin
               iaddr = 32'hBAD0_0000; daddr = 32'hBAD0_0004; dwd = 32'h0BAD_0BAD;
               dbe = ~t.be; dwr = !t.wr;
            end
            acc = (c >= 1) && (c <= lat);
            rsp = (c == lat + 1);
            chk($sformatf("v%0d_c%0d_ctl{mre,mwe,mbe,gnt,busy,ir,dr}", v, c),
                64'({s_mre, s_mwe, s_mbe, s_gnt, s_busy, s_ir, s_dr}),
                64'({acc && !t.wr, t.wr && (c == lat), acc ? t.exp_be : 4'h0,
                     (acc || rsp) ? t.exp_gnt : 2'b00, acc || rsp, rsp && !t.isd, rsp && t.isd}));
            chk($sformatf("v%0d_c%0d_maddr", v, c), 64'(s_ma), 64'(acc ? t.addr : 32'h0));
            chk($sformatf("v%0d_c%0d_mwdata", v, c), 64'(s_mwd), 64'((acc && t.wr) ? t.wdata : 32'h0));
            chk($sformatf("v%0d_c%0d_rdata{i,d}", v, c), {s_ird, s_drd},
                {(rsp && !t.isd) ? t.exp_rd : 32'h0, (rsp && t.isd) ? t.exp_rd : 32'h0});
            if (rsp) begin ireq = 1'b0; dreq = 1'b0; end
         end
      end

      // Tie right after reset at latency 1: data first, then instruction.
      reset_all();
      sel3 = 1'b0;
      ireq = 1'b1; dreq = 1'b1; dwr = 1'b0; dbe = 4'hF;
      iaddr = 32'h0040_0000; daddr = 32'h1001_0000; mrd = 32'h0000_0011;
      dr_at = -1; ir_at = -1; npl = 0;
      for (int c = 1; c <= 7; c++) begin
         step();
         if (c == 1) chk("tie_gnt_c1", 64'(s_gnt), 64'(2'b10));
         if (c == 4) chk("tie_gnt_c4", 64'(s_gnt), 64'(2'b01));
         if (s_dr) begin npl++; if (dr_at < 0) dr_at = c; dreq = 1'b0; end
         if (s_ir) begin npl++; if (ir_at < 0) ir_at = c; ireq = 1'b0; end
      end
      chk("tie_dready_cycle", 64'(dr_at), 64'(2));
      chk("tie_iready_cycle", 64'(ir_at), 64'(5));
      chk("tie_pulse_count", 64'(npl), 64'(2));

      // Both sides requesting continuously at latency 3: alternating D, I with 5-cycle spacing.
      reset_all();
      sel3 = 1'b1;
      ireq = 1'b1; dreq = 1'b1; dwr = 1'b0; mrd = 32'h0BAD_F00D;
      np = 0;
      for (int c = 1; c <= 41; c++) begin
         step();
         if (s_ir || s_dr) begin
            chk($sformatf("rr_pulse%0d_cycle", np), 64'(c), 64'(4 + 5 * np));
            chk($sformatf("rr_pulse%0d_side{ir,dr}", np), 64'({s_ir, s_dr}),
                64'(((np % 2) != 0) ? 2'b10 : 2'b01));
            np++;
         end
      end
      chk("rr_pulse_count", 64'(np), 64'(8));

      // Reset in the second access cycle of a latency-3 store.
      reset_all();
      sel3 = 1'b1;
      dreq = 1'b1; dwr = 1'b1; daddr = 32'h1001_0000; dwd = 32'hDEAD_BEEF; dbe = 4'h3;
      step();
      chk("rst_mid_c1_mwe", 64'(s_mwe), 0);
      step();
      chk("rst_mid_c2_{mwe,busy}", 64'({s_mwe, s_busy}), 64'(2'b01));
      rst = 1'b1;
      #1;
      chk("rst_mid_async_zero", 64'(|{ir3, ird3, dr3, drd3, mre3, mwe3, mbe3, ma3, mwd3, gnt3, busy3}), 0);
      for (int c = 0; c < 3; c++) begin
         step();
         chk($sformatf("rst_mid_hold%0d_{mwe,ir,dr}", c), 64'({s_mwe, s_ir, s_dr}), 0);
      end
      rst = 1'b0;
      dwr = 1'b0; ireq = 1'b1; dreq = 1'b1; mrd = 32'h0000_0077;
      for (int c = 1; c <= 4; c++) begin
         step();
         if (c == 1) chk("rst_mid_tie_gnt", 64'(s_gnt), 64'(2'b10));
         if (c == 3) chk("rst_mid_no_early_ready", 64'({s_ir, s_dr}), 0);
         if (c == 4) chk("rst_mid_tie_dready{ir,dr}", 64'({s_ir, s_dr}), 64'(2'b01));
      end

      // Data request dropped in cycle 1 of a latency-3 load.
      reset_all();
      sel3 = 1'b1;
      dreq = 1'b1; dwr = 1'b0; daddr = 32'h1001_0010; dbe = 4'hF; mrd = 32'h55AA_55AA;
      for (int c = 1; c <= 8; c++) begin
         step();
         if (c == 1) dreq = 1'b0;
         chk($sformatf("drop_c%0d_{dr,busy}", c), 64'({s_dr, s_busy}), 64'({c == 4, c <= 4}));
         if (c == 4) chk("drop_rdata", 64'(s_drd), 64'(32'h55AA_55AA));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares one single-ported memory between the RISC-V core's instruction-fetch bus and data bus. It is the next step toward a multicycle or pipelined core with unified memory. The block accepts one access at a time. It drives the shared memory port for a fixed number of wait cycles, returns registered read data with a one-cycle ready pulse, and alternates grants round-robin when both sides request.

## Interface
Parameters:
- MEM_LATENCY, 1: cycles the memory port is held per access. Valid range is 1 to 15.

Ports:
- iCLK  in  1  clock
- iRST  in  1  reset, asynchronous, active-high
- iIReq  in  1  instruction fetch request; held until oIReady
- iIAddress  in  32  fetch address
- oIReady  out  1  one-cycle pulse; fetch done
- oIReadData  out  32  fetched word, valid while oIReady=1
- iDReq  in  1  data request; held until oDReady
- iDWrite  in  1  1 = store, 0 = load
- iDByteEnable  in  4  store byte lanes
- iDAddress  in  32  data address
- iDWriteData  in  32  store data
- oDReady  out  1  one-cycle pulse; data access done
- oDReadData  out  32  load word, valid while oDReady=1; 0 for stores
- oMReadEnable, oMWriteEnable  out  1  memory port strobes
- oMByteEnable  out  4  memory byte lanes; 4'b1111 for all reads
- oMAddress, oMWriteData  out  32  memory address and data
- iMReadData  in  32  memory read data
- oGrant  out  2  monitor: 00 none, 01 instruction, 10 data
- oBusy  out  1  monitor: state ≠ IDLE

## Operation
- FSM states are IDLE, ACCESS and RESPOND.
- IDLE:
  - If any request is present, pick a winner and latch its address, write data, byte enables and type into registers.
  - Load the wait counter with MEM_LATENCY-1 and go to ACCESS.
- Arbitration:
  - With a single requester, that requester wins.
  - With both requesting, the side not served last wins.
  - The last-served register resets to instruction, so data wins the first tie.
- ACCESS:
  - All memory outputs come from the latched registers and stay constant.
  - oMReadEnable=1 for reads.
  - oMWriteEnable=1 only on the final ACCESS cycle (counter=0), so there is exactly one write strobe per store.
  - The counter decrements each cycle. At counter=0, iMReadData is captured (loads and fetches only) and the FSM goes to RESPOND.
- RESPOND:
  - Pulse the winner's ready output with the captured data and update the last-served register.
  - Memory strobes are 0. The FSM always returns to IDLE.
- Requester rule: deassert the request on the clock edge that samples ready. The arbiter never re-grants during RESPOND.
- Request dropped mid-access: the access still completes and the ready pulse is still issued. The requester ignores it.
- Inputs changing after the grant have no effect on the access in flight, because everything is latched.
- Outputs idle at 0: strobes, byte enables, address, write data, ready, read data, oGrant.

## Timing
- Reset: every output is 0 immediately (asynchronous). State goes to IDLE and last-served to instruction. An in-flight access is aborted with no strobe and no ready pulse.
- With a request present at cycle 0 (IDLE):
  - memory strobes are active in cycles 1 through MEM_LATENCY;
  - ready pulses in cycle MEM_LATENCY+1;
  - the next grant is possible in cycle MEM_LATENCY+2.
- Throughput is one access per MEM_LATENCY+2 cycles.
- Read data is sampled at the rising edge that ends the last ACCESS cycle. The memory must present data by then.
- oGrant is valid during ACCESS and RESPOND.

## Structure
- Shared package contents:
  - state encoding: ST_IDLE, ST_ACCESS, ST_RESPOND;
  - grant constants: GNT_NONE=2'b00, GNT_I=2'b01, GNT_D=2'b10;
  - the BE_WORD=4'b1111 constant.
- Sub-module arb_rr2: combinational two-way round-robin pick from (reqI, reqD, lastServed) to a grant. Everything else stays in the top module.

## Test plan
- Fetch, MEM_LATENCY=1:
  - iIReq with address 0x00400000, memory returns 0x00000013.
  - Expect oMReadEnable=1 and oMAddress=0x00400000 in cycle 1.
  - Expect oIReady=1 and oIReadData=0x00000013 in cycle 2, with oGrant=01.
- Tie after reset, MEM_LATENCY=1:
  - iIReq and iDReq both rise in cycle 0.
  - Expect data served first: oDReady in cycle 2.
  - Expect the instruction served next: oIReady in cycle 5.
- Store, MEM_LATENCY=3:
  - Address 0x10010000, data 0xDEADBEEF, byte enable 4'b0011.
  - Expect oMWriteEnable=1 only in cycle 3, with the matching address, data and byte enable.
  - Expect oDReady in cycle 4 with oDReadData=0.
- Both sides requesting continuously for 8 accesses:
  - Expect grants D, I, D, I, …
  - Expect exactly one ready pulse per access, spaced MEM_LATENCY+2 cycles apart.
- Reset mid-access:
  - Assert iRST during the second ACCESS cycle of a store with MEM_LATENCY=3.
  - Expect all outputs 0 immediately, no write strobe and no ready pulse.
  - After release, a new tie grants data first.
- Request dropped:
  - iDReq falls in cycle 1 of a load.
  - Expect oDReady still in cycle MEM_LATENCY+1 and no second grant.
